sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Controller in front of one 512x64 1R1W described SRAM macro (registered read address; read data valid the cycle after R0_en).
- Shares the memory between two requesters using round-robin arbitration, with one round-robin arbiter per memory port.
- Zero-fills the whole array after reset, and again on request.
- Resolves same-address read/write collisions so that read data is deterministic.

Parameters:
- ADDR_W, 9: address width; DEPTH = 2**ADDR_W.
- DATA_W, 64: data width.
- INIT_VALUE, 64'h0: word written to every entry during fill.

Ports:
- clock  in  1  single clock; the memory R0_clk and W0_clk must be tied to it.
- reset  in  1  asynchronous, active-high.
- cN_req_valid  in  1  request from client N (N = 0,1).
- cN_req_ready  out  1  request accepted this cycle.
- cN_req_write  in  1  1 = write, 0 = read.
- cN_req_addr  in  ADDR_W  word address.
- cN_req_wdata  in  DATA_W  write data.
- cN_resp_valid  out  1  read data valid; no backpressure.
- cN_resp_rdata  out  DATA_W  read data.
- mem_R0_en / mem_R0_addr  out  1 / ADDR_W  memory read port.
- mem_R0_data  in  DATA_W  memory read data.
- mem_W0_en / mem_W0_addr / mem_W0_data  out  1 / ADDR_W / DATA_W  memory write port.
- init_req  in  1  pulse: re-fill the array with INIT_VALUE.
- init_done  out  1  high while in RUN.

Behaviour:
- Reset state:
  - While reset is asserted: state = RST_WAIT, fill counter = 0, both round-robin pointers = client 0, rd_pend = 0.
  - All outputs are 0: ready, resp_valid, mem enables, init_done.
- RST_WAIT: lasts one cycle after reset deasserts, with no memory activity; then moves to FILL.
- FILL:
  - Each cycle: mem_W0_en = 1, mem_W0_addr = counter, mem_W0_data = INIT_VALUE; counter increments.
  - When counter = DEPTH-1, the write completes and the state moves to RUN. The fill is exactly DEPTH cycles.
  - cN_req_ready = 0 throughout FILL.
  - init_req is ignored in FILL.
- RUN:
  - init_done = 1.
  - init_req sampled high: the next state is FILL with counter reset to 0. No grants are issued in the cycle init_req is sampled.
  - A read granted in the previous cycle still returns its response normally.
- Read arbitration (RUN only):
  - Candidates are clients with valid = 1 and write = 0.
  - One candidate: it is granted.
  - Two candidates: the client pointed to by rd_ptr wins, then rd_ptr moves to the other client.
  - rd_ptr changes only on a contended grant.
- Write arbitration: identical, using wr_ptr and candidates with valid = 1 and write = 1.
  - A read and a write from different clients may both be granted in the same cycle.
- Grant mapping:
  - ready = grant, combinational from the valid/write/addr inputs and registered state.
  - A granted read drives mem_R0_en/addr; a granted write drives mem_W0_en/addr/data.
- Hazard:
  - If the granted read address equals the granted write address in the same cycle, the write proceeds and the read is not granted (its ready = 0).
  - The read wins the following cycle unless the hazard repeats.
  - A read never observes a same-cycle write.
- Response path:
  - Granted read at cycle t: rd_pend = 1 and rd_owner = client registered; at t+1 cN_resp_valid = 1 for the owner only.
  - cN_resp_rdata = mem_R0_data, routed combinationally.
  - Non-owner cN_resp_rdata = 0.
- Latency: one cycle from request handshake to response; throughput of one read plus one write per cycle.
- Reset mid-FILL or mid-RUN: immediate return to RST_WAIT. Pending responses are dropped and the fill restarts from address 0.
- No combinational path from mem_R0_data to any ready output.

Decomposition:
- Package sram_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - state_e {RST_WAIT, FILL, RUN}.
  - req_t struct {write, addr, wdata}.
  - client_id_t (1 bit).
- Sub-module rr_arb2:
  - Two-request round-robin arbiter with registered pointer and async reset.
  - Instantiated twice, once for the read port and once for the write port.

Test Plan:
- Reset, then release → exactly 512 consecutive W0 writes, addr 0..511 with data 0; init_done rises on cycle 513 after release; ready stays 0 until then.
- RUN; c0 reads addr 5 and c1 reads addr 9 in the same cycle, repeated 4 cycles → grants c0,c1,c0,c1; each resp_valid arrives one cycle after its grant with the correct data.
- c0 writes 0xDEAD_BEEF to addr 3 while c1 reads addr 7 in the same cycle → both ready = 1; c1 resp next cycle holds the old addr-7 data.
- c0 writes 0x1234 to addr 10 while c1 reads addr 10 → c1 ready = 0 that cycle, granted next cycle; c1 resp data = 0x1234.
- init_req pulsed the same cycle a read response is due → response still delivered; init_done drops; 512 fill writes follow; ready is held 0 throughout.
- Reset asserted at fill count 200 → outputs go to 0 immediately; after release the fill restarts at addr 0 and completes all 512 writes.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-client SRAM port arbiter.
// Widths, FSM states and request bundle.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    RST_WAIT,
    FILL,
    RUN
  } state_e;

  typedef logic client_id_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-request round-robin arbiter.
// Pointer only moves on a committed contended grant.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       commit,
  output logic [1:0] gnt
);

  client_id_t ptr;

  // grant the sole requester, or the pointed-to one on contention
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // hand priority to the loser after a contended grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (commit && req == 2'b11) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-client controller for a 1R1W SRAM macro.
// Zero-fills after reset or on request, then arbitrates.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c0_req_valid,
  output logic              c0_req_ready,
  input  logic              c0_req_write,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [DATA_W-1:0] c0_req_wdata,
  output logic              c0_resp_valid,
  output logic [DATA_W-1:0] c0_resp_rdata,
  input  logic              c1_req_valid,
  output logic              c1_req_ready,
  input  logic              c1_req_write,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [DATA_W-1:0] c1_req_wdata,
  output logic              c1_resp_valid,
  output logic [DATA_W-1:0] c1_resp_rdata,
  output logic              mem_R0_en,
  output logic [ADDR_W-1:0] mem_R0_addr,
  input  logic [DATA_W-1:0] mem_R0_data,
  output logic              mem_W0_en,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic [DATA_W-1:0] mem_W0_data,
  input  logic              init_req,
  output logic              init_done
);

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic              rd_pend;
  client_id_t        rd_owner;

  logic              in_fill;
  logic              run_ok;
  logic [1:0]        rd_req;
  logic [1:0]        wr_req;
  logic [1:0]        rd_gnt;
  logic [1:0]        wr_gnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              hazard;
  logic              rd_fire;
  logic              wr_fire;

  assign in_fill = (state == FILL);
  assign run_ok  = (state == RUN) && !init_req;

  assign rd_req = {c1_req_valid & ~c1_req_write,
                   c0_req_valid & ~c0_req_write}
                & {2{run_ok}};
  assign wr_req = {c1_req_valid & c1_req_write,
                   c0_req_valid & c0_req_write}
                & {2{run_ok}};

  rr_arb2 u_rd_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (rd_req),
    .commit (~hazard),
    .gnt    (rd_gnt)
  );

  rr_arb2 u_wr_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (wr_req),
    .commit (1'b1),
    .gnt    (wr_gnt)
  );

  assign rd_addr = rd_gnt[1] ? c1_req_addr : c0_req_addr;
  assign wr_addr = wr_gnt[1] ? c1_req_addr : c0_req_addr;
  assign wr_data = wr_gnt[1] ? c1_req_wdata : c0_req_wdata;

  // a same-address read is deferred so it sees the written data
  assign hazard  = (|rd_gnt) && (|wr_gnt) && (rd_addr == wr_addr);
  assign rd_fire = (|rd_gnt) && !hazard;
  assign wr_fire = |wr_gnt;

  assign c0_req_ready = (rd_gnt[0] & ~hazard) | wr_gnt[0];
  assign c1_req_ready = (rd_gnt[1] & ~hazard) | wr_gnt[1];

  assign mem_R0_en   = rd_fire;
  assign mem_R0_addr = rd_fire ? rd_addr : '0;

  assign mem_W0_en   = in_fill | wr_fire;
  assign mem_W0_addr = in_fill ? cnt
                     : wr_fire ? wr_addr : '0;
  assign mem_W0_data = in_fill ? INIT_VALUE
                     : wr_fire ? wr_data : '0;

  assign init_done = (state == RUN);

  assign c0_resp_valid = rd_pend && (rd_owner == 1'b0);
  assign c1_resp_valid = rd_pend && (rd_owner == 1'b1);
  assign c0_resp_rdata = c0_resp_valid ? mem_R0_data : '0;
  assign c1_resp_rdata = c1_resp_valid ? mem_R0_data : '0;

  // fill/run sequencing and read-response tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RST_WAIT;
      cnt      <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= rd_fire;
      if (rd_fire) begin
        rd_owner <= rd_gnt[1];
      end
      unique case (state)
        RST_WAIT: begin
          state <= FILL;
          cnt   <= '0;
        end
        FILL: begin
          cnt <= cnt + 1'b1;
          // all-ones counter is the last word
          if (&cnt) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (init_req) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        default: state <= RST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter.
// Includes a behavioural SRAM macro and a reference model.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          c0_req_valid, c0_req_ready, c0_req_write;
  logic [AW-1:0] c0_req_addr;
  logic [DW-1:0] c0_req_wdata;
  logic          c0_resp_valid;
  logic [DW-1:0] c0_resp_rdata;
  logic          c1_req_valid, c1_req_ready, c1_req_write;
  logic [AW-1:0] c1_req_addr;
  logic [DW-1:0] c1_req_wdata;
  logic          c1_resp_valid;
  logic [DW-1:0] c1_resp_rdata;
  logic          mem_R0_en;
  logic [AW-1:0] mem_R0_addr;
  logic [DW-1:0] mem_R0_data;
  logic          mem_W0_en;
  logic [AW-1:0] mem_W0_addr;
  logic [DW-1:0] mem_W0_data;
  logic          init_req;
  logic          init_done;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_ptr_m = 0;
  int wr_ptr_m = 0;

  logic [DW-1:0] sram    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clock = ~clock;

  sram_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .INIT_VALUE (64'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .c0_req_valid  (c0_req_valid),
    .c0_req_ready  (c0_req_ready),
    .c0_req_write  (c0_req_write),
    .c0_req_addr   (c0_req_addr),
    .c0_req_wdata  (c0_req_wdata),
    .c0_resp_valid (c0_resp_valid),
    .c0_resp_rdata (c0_resp_rdata),
    .c1_req_valid  (c1_req_valid),
    .c1_req_ready  (c1_req_ready),
    .c1_req_write  (c1_req_write),
    .c1_req_addr   (c1_req_addr),
    .c1_req_wdata  (c1_req_wdata),
    .c1_resp_valid (c1_resp_valid),
    .c1_resp_rdata (c1_resp_rdata),
    .mem_R0_en     (mem_R0_en),
    .mem_R0_addr   (mem_R0_addr),
    .mem_R0_data   (mem_R0_data),
    .mem_W0_en     (mem_W0_en),
    .mem_W0_addr   (mem_W0_addr),
    .mem_W0_data   (mem_W0_data),
    .init_req      (init_req),
    .init_done     (init_done)
  );

  // behavioural 1R1W macro: registered read, old data on collision
  always @(posedge clock) begin
    if (mem_W0_en) sram[mem_W0_addr] <= mem_W0_data;
    if (mem_R0_en) mem_R0_data <= sram[mem_R0_addr];
  end

  // garbage initial contents so the fill is observable
  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] <= {$urandom, $urandom};
  end

  task automatic drive(input int c, input logic v, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (c == 0) begin
      c0_req_valid = v; c0_req_write = w;
      c0_req_addr  = a; c0_req_wdata = d;
    end else begin
      c1_req_valid = v; c1_req_write = w;
      c1_req_addr  = a; c1_req_wdata = d;
    end
  endtask

  task automatic clr();
    drive(0, 1'b0, 1'b0, '0, 64'h0);
    drive(1, 1'b0, 1'b0, '0, 64'h0);
    init_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, AW'(5), 64'h0);
    drive(1, 1'b1, 1'b1, AW'(6), 64'h1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({c0_req_ready, c1_req_ready, c0_resp_valid, c1_resp_valid,
         mem_R0_en, mem_W0_en, init_done} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b%b%b%b%b%b%b want 0000000",
               c0_req_ready, c1_req_ready, c0_resp_valid, c1_resp_valid,
               mem_R0_en, mem_W0_en, init_done);
    end
  endtask

  // starts at posedge+1 of the first fill cycle
  task automatic watch_fill(input string tag, input int poke);
    int bad;
    for (int i = 0; i < DEPTH; i++) begin
      init_req = (i == poke);
      @(negedge clock);
      n_cmp++;
      if (mem_W0_en !== 1'b1 || mem_W0_addr !== AW'(i) ||
          mem_W0_data !== 64'h0 || c0_req_ready !== 1'b0 ||
          c1_req_ready !== 1'b0 || init_done !== 1'b0 ||
          mem_R0_en !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_write_%0d: got en=%b addr=%0d data=%h rdy=%b%b done=%b ren=%b want en=1 addr=%0d data=0 rdy=00 done=0 ren=0",
                 tag, i, mem_W0_en, mem_W0_addr, mem_W0_data,
                 c0_req_ready, c1_req_ready, init_done, mem_R0_en, i);
      end
      @(posedge clock); #1;
    end
    clr();
    @(negedge clock);
    n_cmp++;
    if (init_done !== 1'b1 || mem_W0_en !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done: got done=%b wen=%b want done=1 wen=0",
               tag, init_done, mem_W0_en);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (sram[i] !== 64'h0) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s_contents: got %0d nonzero words want 0", tag, bad);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'h0;
  endtask

  task automatic test_fill(input string tag);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, AW'(1), 64'h0);
    drive(1, 1'b1, 1'b1, AW'(2), 64'h55);
    @(negedge clock);
    n_cmp++;
    if (mem_W0_en !== 1'b0 || init_done !== 1'b0 || mem_R0_en !== 1'b0 ||
        c0_req_ready !== 1'b0 || c1_req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_rst_wait: got wen=%b done=%b ren=%b rdy=%b%b want all 0",
               tag, mem_W0_en, init_done, mem_R0_en,
               c0_req_ready, c1_req_ready);
    end
    @(posedge clock); #1;
    watch_fill(tag, -1);
    rd_ptr_m = 0;
    wr_ptr_m = 0;
  endtask

  task automatic test_contended_reads();
    logic [DW-1:0] d5, d9;
    int exp_g [4] = '{0, 1, 0, 1};
    int own;
    @(posedge clock); #1;
    d5 = {$urandom, $urandom};
    d9 = {$urandom, $urandom};
    drive(0, 1'b1, 1'b1, AW'(5), d5);
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b1, AW'(9), d9);
    @(posedge clock); #1;
    ref_mem[5] = d5;
    ref_mem[9] = d9;
    drive(0, 1'b1, 1'b0, AW'(5), 64'h0);
    drive(1, 1'b1, 1'b0, AW'(9), 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_cmp++;
      if (c0_req_ready !== (exp_g[k] == 0) ||
          c1_req_ready !== (exp_g[k] == 1)) begin
        n_bad++;
        $display("FAIL rr_grant_%0d: got rdy=%b%b want winner c%0d",
                 k, c0_req_ready, c1_req_ready, exp_g[k]);
      end
      if (k > 0) begin
        own = exp_g[k-1];
        n_cmp++;
        if (c0_resp_valid !== (own == 0) || c1_resp_valid !== (own == 1) ||
            c0_resp_rdata !== (own == 0 ? d5 : 64'h0) ||
            c1_resp_rdata !== (own == 1 ? d9 : 64'h0)) begin
          n_bad++;
          $display("FAIL rr_resp_%0d: got v=%b%b d0=%h d1=%h want owner c%0d",
                   k, c0_resp_valid, c1_resp_valid,
                   c0_resp_rdata, c1_resp_rdata, own);
        end
      end
      @(posedge clock); #1;
    end
    clr();
    @(negedge clock);
    n_cmp++;
    if (c1_resp_valid !== 1'b1 || c1_resp_rdata !== d9 ||
        c0_resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_resp_last: got v=%b%b d1=%h want v=01 d1=%h",
               c0_resp_valid, c1_resp_valid, c1_resp_rdata, d9);
    end
  endtask

  task automatic test_rw_parallel();
    logic [DW-1:0] old7;
    @(posedge clock); #1;
    old7 = {$urandom, $urandom};
    drive(1, 1'b1, 1'b1, AW'(7), old7);
    @(posedge clock); #1;
    ref_mem[7] = old7;
    drive(0, 1'b1, 1'b1, AW'(3), 64'hDEAD_BEEF);
    drive(1, 1'b1, 1'b0, AW'(7), 64'h0);
    @(negedge clock);
    n_cmp++;
    if (c0_req_ready !== 1'b1 || c1_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rw_both_ready: got rdy=%b%b want 11",
               c0_req_ready, c1_req_ready);
    end
    @(posedge clock); #1;
    clr();
    ref_mem[3] = 64'hDEAD_BEEF;
    @(negedge clock);
    n_cmp++;
    if (c1_resp_valid !== 1'b1 || c1_resp_rdata !== old7 ||
        c0_resp_valid !== 1'b0 || c0_resp_rdata !== 64'h0) begin
      n_bad++;
      $display("FAIL rw_resp: got v=%b%b d1=%h d0=%h want v=01 d1=%h d0=0",
               c0_resp_valid, c1_resp_valid, c1_resp_rdata,
               c0_resp_rdata, old7);
    end
    n_cmp++;
    if (sram[3] !== 64'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL rw_write: got mem[3]=%h want deadbeef", sram[3]);
    end
  endtask

  task automatic test_hazard();
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b1, AW'(10), 64'h1234);
    drive(1, 1'b1, 1'b0, AW'(10), 64'h0);
    @(negedge clock);
    n_cmp++;
    if (c0_req_ready !== 1'b1 || c1_req_ready !== 1'b0 ||
        mem_R0_en !== 1'b0) begin
      n_bad++;
      $display("FAIL hazard_block: got rdy=%b%b ren=%b want rdy=10 ren=0",
               c0_req_ready, c1_req_ready, mem_R0_en);
    end
    @(posedge clock); #1;
    ref_mem[10] = 64'h1234;
    drive(0, 1'b0, 1'b0, '0, 64'h0);
    @(negedge clock);
    n_cmp++;
    if (c1_req_ready !== 1'b1 || c1_resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hazard_retry: got rdy1=%b v1=%b want rdy1=1 v1=0",
               c1_req_ready, c1_resp_valid);
    end
    @(posedge clock); #1;
    clr();
    @(negedge clock);
    n_cmp++;
    if (c1_resp_valid !== 1'b1 || c1_resp_rdata !== 64'h1234) begin
      n_bad++;
      $display("FAIL hazard_resp: got v1=%b d1=%h want v1=1 d1=1234",
               c1_resp_valid, c1_resp_rdata);
    end
  endtask

  task automatic test_random();
    req_t r [2];
    logic v [2];
    int rc [$];
    int wc [$];
    int rw, ww, pend, bad;
    logic [DW-1:0] pend_data;
    pend = -1;
    pend_data = 64'h0;
    @(posedge clock); #1;
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 2; c++) begin
        v[c]       = ($urandom_range(0, 3) != 0);
        r[c].write = 1'($urandom_range(0, 1));
        r[c].addr  = AW'($urandom_range(0, 3));
        r[c].wdata = {$urandom, $urandom};
        drive(c, v[c], r[c].write, r[c].addr, r[c].wdata);
      end
      rc.delete();
      wc.delete();
      for (int c = 0; c < 2; c++) begin
        if (v[c] && !r[c].write) rc.push_back(c);
        if (v[c] && r[c].write)  wc.push_back(c);
      end
      rw = -1;
      ww = -1;
      if (rc.size() == 1) rw = rc[0];
      else if (rc.size() == 2) begin
        rw = rd_ptr_m;
        rd_ptr_m = 1 - rd_ptr_m;
      end
      if (wc.size() == 1) ww = wc[0];
      else if (wc.size() == 2) begin
        ww = wr_ptr_m;
        wr_ptr_m = 1 - wr_ptr_m;
      end
      if (rw >= 0 && ww >= 0 && r[rw].addr == r[ww].addr) rw = -1;
      @(negedge clock);
      n_cmp++;
      if (c0_req_ready !== (rw == 0 || ww == 0) ||
          c1_req_ready !== (rw == 1 || ww == 1)) begin
        n_bad++;
        $display("FAIL rand_ready_%0d: got rdy=%b%b want rd=c%0d wr=c%0d",
                 n, c0_req_ready, c1_req_ready, rw, ww);
      end
      n_cmp++;
      if (c0_resp_valid !== (pend == 0) || c1_resp_valid !== (pend == 1) ||
          c0_resp_rdata !== (pend == 0 ? pend_data : 64'h0) ||
          c1_resp_rdata !== (pend == 1 ? pend_data : 64'h0)) begin
        n_bad++;
        $display("FAIL rand_resp_%0d: got v=%b%b d0=%h d1=%h want owner=%0d data=%h",
                 n, c0_resp_valid, c1_resp_valid, c0_resp_rdata,
                 c1_resp_rdata, pend, pend_data);
      end
      pend = rw;
      if (rw >= 0) pend_data = ref_mem[r[rw].addr];
      if (ww >= 0) ref_mem[r[ww].addr] = r[ww].wdata;
      @(posedge clock); #1;
    end
    clr();
    @(negedge clock);
    n_cmp++;
    if (c0_resp_valid !== (pend == 0) || c1_resp_valid !== (pend == 1) ||
        c0_resp_rdata !== (pend == 0 ? pend_data : 64'h0) ||
        c1_resp_rdata !== (pend == 1 ? pend_data : 64'h0)) begin
      n_bad++;
      $display("FAIL rand_resp_last: got v=%b%b d0=%h d1=%h want owner=%0d data=%h",
               c0_resp_valid, c1_resp_valid, c0_resp_rdata,
               c1_resp_rdata, pend, pend_data);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL rand_contents: got %0d differing words want 0", bad);
    end
  endtask

  task automatic test_init_req();
    logic [AW-1:0] a;
    logic [DW-1:0] exp_d;
    @(posedge clock); #1;
    a = AW'($urandom_range(0, 3));
    exp_d = ref_mem[a];
    drive(0, 1'b1, 1'b0, a, 64'h0);
    @(negedge clock);
    n_cmp++;
    if (c0_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL init_pre_grant: got rdy0=%b want 1", c0_req_ready);
    end
    @(posedge clock); #1;
    init_req = 1'b1;
    drive(1, 1'b1, 1'b1, AW'(4), 64'h77);
    @(negedge clock);
    n_cmp++;
    if (c0_req_ready !== 1'b0 || c1_req_ready !== 1'b0 ||
        mem_W0_en !== 1'b0 || mem_R0_en !== 1'b0) begin
      n_bad++;
      $display("FAIL init_no_grant: got rdy=%b%b wen=%b ren=%b want all 0",
               c0_req_ready, c1_req_ready, mem_W0_en, mem_R0_en);
    end
    n_cmp++;
    if (c0_resp_valid !== 1'b1 || c0_resp_rdata !== exp_d ||
        c1_resp_valid !== 1'b0 || init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL init_resp: got v=%b%b d0=%h done=%b want v=10 d0=%h done=1",
               c0_resp_valid, c1_resp_valid, c0_resp_rdata,
               init_done, exp_d);
    end
    @(posedge clock); #1;
    watch_fill("refill", 100);
  endtask

  task automatic test_reset_mid_fill();
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b0, AW'(1), 64'h0);
    @(posedge clock); #1;
    clr();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (c0_resp_valid !== 1'b0 || init_done !== 1'b0 ||
        mem_W0_en !== 1'b0 || mem_R0_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_run_drop: got v0=%b done=%b wen=%b ren=%b want all 0",
               c0_resp_valid, init_done, mem_W0_en, mem_R0_en);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, AW'(2), 64'h0);
    @(posedge clock); #1;
    repeat (200) @(posedge clock);
    #1;
    @(negedge clock);
    n_cmp++;
    if (mem_W0_en !== 1'b1 || mem_W0_addr !== AW'(200)) begin
      n_bad++;
      $display("FAIL fill_count_200: got wen=%b addr=%0d want wen=1 addr=200",
               mem_W0_en, mem_W0_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({c0_req_ready, c1_req_ready, c0_resp_valid, c1_resp_valid,
         mem_R0_en, mem_W0_en, init_done} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_mid_fill: got %b%b%b%b%b%b%b want 0000000",
               c0_req_ready, c1_req_ready, c0_resp_valid, c1_resp_valid,
               mem_R0_en, mem_W0_en, init_done);
    end
    test_fill("fill_after_reset");
  endtask

  initial begin
    clr();
    test_reset();
    test_fill("fill");
    test_contended_reads();
    test_rw_parallel();
    test_hazard();
    test_random();
    test_init_req();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
